// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: two-master, one-slave arbiter for the Avalon-style MIPS memory bus.
//
// Grants one whole transfer at a time to m0 (CPU port) or m1 (loader/DMA) and forwards the
// granted master's strobes, address, data and byte enables to the slave. The other master
// sees waitrequest=1 and readdata=0. A watchdog aborts a grant that has seen WAIT_LIMIT
// consecutive stalled cycles and sets the sticky timeout_err flag.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   m0_* / m1_*         master ports: address, read, write, writedata, byteenable in;
//                       readdata, waitrequest out
//   s_*                 slave port: address, read, write, writedata, byteenable out;
//                       readdata, waitrequest in
//   grant               one-hot current grant {m1, m0}; 00 while idle
//   timeout_err         sticky watchdog flag, cleared only by reset
//
// Build option: define MIPS_BUS_ARB_ROUND_ROBIN_EN to break simultaneous requests in favour
// of the master that did not complete last; otherwise m0 always wins ties.

module mips_bus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WAIT_LIMIT = 256
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,

  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest,

  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_LIMIT - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(WAIT_LIMIT);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;  // 1: m1 completed last
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_err_q, timeout_err_d;

  logic m0_req, m1_req, gnt_req, timeout_hit;

  assign m0_req  = m0_read | m0_write;
  assign m1_req  = m1_read | m1_write;
  assign gnt_req = (state_q == StGnt1) ? m1_req : m0_req;

  // Last stalled cycle the watchdog tolerates: abort the transfer in this very cycle.
  assign timeout_hit = (state_q != StIdle) && s_waitrequest && (cnt_q == CntLast);

  assign timeout_err = timeout_err_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;  // m0 wins the first tie
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (m0_req && m1_req) begin
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
          state_d = last_grant_q ? StGnt0 : StGnt1;
`else
          state_d = StGnt0;
`endif
        end else if (m0_req) begin
          state_d = StGnt0;
        end else if (m1_req) begin
          state_d = StGnt1;
        end
      end
      StGnt0, StGnt1: begin
        if (timeout_hit) begin
          state_d       = StIdle;
          timeout_err_d = 1'b1;
          cnt_d         = '0;
        end else if (!gnt_req) begin
          // Abandoned transfer: fairness history is left untouched.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!s_waitrequest) begin
          state_d      = StIdle;
          last_grant_d = (state_q == StGnt1);
          cnt_d        = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_readdata    = '0;
    m0_waitrequest = 1'b1;
    m1_readdata    = '0;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    unique case (state_q)
      StGnt0: begin
        grant          = 2'b01;
        s_address      = m0_address;
        s_read         = m0_read & ~timeout_hit;
        s_write        = m0_write & ~timeout_hit;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_readdata    = timeout_hit ? '0 : s_readdata;
        m0_waitrequest = timeout_hit ? 1'b0 : s_waitrequest;
      end
      StGnt1: begin
        grant          = 2'b10;
        s_address      = m1_address;
        s_read         = m1_read & ~timeout_hit;
        s_write        = m1_write & ~timeout_hit;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_readdata    = timeout_hit ? '0 : s_readdata;
        m1_waitrequest = timeout_hit ? 1'b0 : s_waitrequest;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for tie arbitration, watchdog, asynchronous reset and abandon.

module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  mips_bus_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .WAIT_LIMIT (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_byteenable  (m0_byteenable),
    .m0_readdata    (m0_readdata),
    .m0_waitrequest (m0_waitrequest),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_readdata    (m1_readdata),
    .m1_waitrequest (m1_waitrequest),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_readdata     (s_readdata),
    .s_waitrequest  (s_waitrequest),
    .grant          (grant),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m0_rd;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m1_rd;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic        sw;
    logic [31:0] srd;
    logic [1:0]  e_gnt;
    logic        e_sread;
    logic [31:0] e_saddr;
    logic [31:0] e_swd;
    logic        e_m0w;
    logic [31:0] e_m0rd;
    logic        e_m1w;
    logic [31:0] e_m1rd;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    s_waitrequest = 1'b0;
    s_readdata = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("rst m1_wait", 32'(m1_waitrequest), 32'h1);
    chk("rst terr", 32'(timeout_err), 32'h0);
    chk("rst s_address", s_address, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_g [6];

    reset = 1'b0;
    m0_address = '0; m0_writedata = '0; m0_byteenable = 4'hF;
    m1_address = '0; m1_writedata = '0; m1_byteenable = 4'h3;
    idle_inputs();

    //         m0_rd m0_addr        m0_wd          m1_rd m1_addr        m1_wd
    //         sw    srd            gnt   sread saddr          swd
    //         m0w   m0rd           m1w   m1rd
    tbl[0] = '{1'b1, 32'hBFC00000, 32'h0,        1'b0, 32'h0,        32'h0,
               1'b1, 32'hAABBCCDD, 2'b00, 1'b0, 32'h0,        32'h0,
               1'b1, 32'h0,        1'b1, 32'h0};
    tbl[1] = '{1'b1, 32'hBFC00000, 32'h0,        1'b0, 32'h0,        32'h0,
               1'b1, 32'hAABBCCDD, 2'b01, 1'b1, 32'hBFC00000, 32'h0,
               1'b1, 32'hAABBCCDD, 1'b1, 32'h0};
    tbl[2] = '{1'b1, 32'hBFC00000, 32'h0,        1'b0, 32'h0,        32'h0,
               1'b0, 32'hAABBCCDD, 2'b01, 1'b1, 32'hBFC00000, 32'h0,
               1'b0, 32'hAABBCCDD, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 32'hBFC00000, 32'h0,        1'b0, 32'h0,        32'h0,
               1'b0, 32'hAABBCCDD, 2'b00, 1'b0, 32'h0,        32'h0,
               1'b1, 32'h0,        1'b1, 32'h0};
    tbl[4] = '{1'b0, 32'h00005555, 32'h00001111, 1'b1, 32'h10000010, 32'hCAFE0001,
               1'b1, 32'h12345678, 2'b00, 1'b0, 32'h0,        32'h0,
               1'b1, 32'h0,        1'b1, 32'h0};
    tbl[5] = '{1'b0, 32'h00006666, 32'h00002222, 1'b1, 32'h10000010, 32'hCAFE0001,
               1'b1, 32'h12345678, 2'b10, 1'b1, 32'h10000010, 32'hCAFE0001,
               1'b1, 32'h0,        1'b1, 32'h12345678};
    tbl[6] = '{1'b1, 32'h00007777, 32'h00003333, 1'b1, 32'h10000010, 32'hCAFE0001,
               1'b0, 32'h12345678, 2'b10, 1'b1, 32'h10000010, 32'hCAFE0001,
               1'b1, 32'h0,        1'b0, 32'h12345678};
    tbl[7] = '{1'b1, 32'h00007777, 32'h00003333, 1'b0, 32'h10000010, 32'hCAFE0001,
               1'b0, 32'h12345678, 2'b00, 1'b0, 32'h0,        32'h0,
               1'b1, 32'h0,        1'b1, 32'h0};
    tbl[8] = '{1'b1, 32'h00007777, 32'h00003333, 1'b0, 32'h10000010, 32'hCAFE0001,
               1'b0, 32'h12345678, 2'b01, 1'b1, 32'h00007777, 32'h00003333,
               1'b0, 32'h12345678, 1'b1, 32'h0};
    tbl[9] = '{1'b0, 32'h00007777, 32'h00003333, 1'b0, 32'h10000010, 32'hCAFE0001,
               1'b0, 32'h12345678, 2'b00, 1'b0, 32'h0,        32'h0,
               1'b1, 32'h0,        1'b1, 32'h0};

    do_reset();

    // Table: single m0 read with one wait cycle, then m1 granted while m0 inputs toggle.
    for (int i = 0; i < 10; i++) begin
      m0_read      = tbl[i].m0_rd;
      m0_address   = tbl[i].m0_addr;
      m0_writedata = tbl[i].m0_wd;
      m1_read      = tbl[i].m1_rd;
      m1_address   = tbl[i].m1_addr;
      m1_writedata = tbl[i].m1_wd;
      s_waitrequest = tbl[i].sw;
      s_readdata    = tbl[i].srd;
      #1;
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].e_gnt));
      chk($sformatf("v%0d s_read", i), 32'(s_read), 32'(tbl[i].e_sread));
      chk($sformatf("v%0d s_address", i), s_address, tbl[i].e_saddr);
      chk($sformatf("v%0d s_writedata", i), s_writedata, tbl[i].e_swd);
      chk($sformatf("v%0d m0_wait", i), 32'(m0_waitrequest), 32'(tbl[i].e_m0w));
      chk($sformatf("v%0d m0_rdata", i), m0_readdata, tbl[i].e_m0rd);
      chk($sformatf("v%0d m1_wait", i), 32'(m1_waitrequest), 32'(tbl[i].e_m1w));
      chk($sformatf("v%0d m1_rdata", i), m1_readdata, tbl[i].e_m1rd);
      chk($sformatf("v%0d terr", i), 32'(timeout_err), 32'h0);
      tick();
    end

    // Both masters write and hold their requests from reset.
    idle_inputs();
    do_reset();
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
    exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
`else
    exp_g = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
`endif
    m0_write = 1'b1;
    m1_write = 1'b1;
    m0_address = 32'h00000100;
    m1_address = 32'h00000200;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("tie c%0d grant", c), 32'(grant), 32'(exp_g[c]));
      chk($sformatf("tie c%0d s_write", c), 32'(s_write), 32'(exp_g[c] != 2'b00));
      tick();
    end

    // Watchdog: m1 read against a slave that never releases waitrequest.
    idle_inputs();
    do_reset();
    m1_read = 1'b1;
    s_waitrequest = 1'b1;
    s_readdata = 32'hDEADBEEF;
    #1;
    chk("wd c0 grant", 32'(grant), 32'h0);
    tick();
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk($sformatf("wd c%0d grant", c), 32'(grant), 32'h2);
      chk($sformatf("wd c%0d terr", c), 32'(timeout_err), 32'h0);
      if (c < 8) begin
        chk($sformatf("wd c%0d m1_wait", c), 32'(m1_waitrequest), 32'h1);
        chk($sformatf("wd c%0d m1_rdata", c), m1_readdata, 32'hDEADBEEF);
        chk($sformatf("wd c%0d s_read", c), 32'(s_read), 32'h1);
      end else begin
        chk("wd abort m1_wait", 32'(m1_waitrequest), 32'h0);
        chk("wd abort m1_rdata", m1_readdata, 32'h0);
        chk("wd abort s_read", 32'(s_read), 32'h0);
      end
      tick();
    end
    #1;
    chk("wd after terr", 32'(timeout_err), 32'h1);
    chk("wd after grant", 32'(grant), 32'h0);
    m1_read = 1'b0;
    s_waitrequest = 1'b0;
    repeat (3) tick();
    chk("wd sticky terr", 32'(timeout_err), 32'h1);
    do_reset();
    #1;
    chk("wd cleared terr", 32'(timeout_err), 32'h0);

    // Asynchronous reset in the middle of a GNT0 transfer.
    idle_inputs();
    m0_read = 1'b1;
    m0_address = 32'h0000ABC0;
    s_waitrequest = 1'b1;
    #1;
    tick();
    #1;
    chk("ar pre grant", 32'(grant), 32'h1);
    chk("ar pre s_read", 32'(s_read), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar s_read", 32'(s_read), 32'h0);
    chk("ar s_write", 32'(s_write), 32'h0);
    chk("ar grant", 32'(grant), 32'h0);
    chk("ar m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("ar m1_wait", 32'(m1_waitrequest), 32'h1);
    chk("ar s_address", s_address, 32'h0);
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Abandon: m0 drops its read while granted, pending m1 follows.
    m0_read = 1'b1;
    m1_read = 1'b1;
    s_waitrequest = 1'b1;
    #1;
    chk("ab c0 grant", 32'(grant), 32'h0);
    tick();
    #1;
    chk("ab c1 grant", 32'(grant), 32'h1);
    tick();
    m0_read = 1'b0;
    #1;
    chk("ab c2 grant", 32'(grant), 32'h1);
    chk("ab c2 s_read", 32'(s_read), 32'h0);
    tick();
    #1;
    chk("ab c3 grant", 32'(grant), 32'h0);
    tick();
    #1;
    chk("ab c4 grant", 32'(grant), 32'h2);
    chk("ab c4 s_read", 32'(s_read), 32'h1);
    chk("ab c4 s_byteenable", 32'(s_byteenable), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
